// File: rtl/count_sequence_checker_pkg.sv
// Shared types and default widths for the count sequence checker slice.
// Holds the FSM state encoding and the event codes reported on the event port.
package count_chk_pkg;

   localparam int CNT_W_DEF       = 4;
   localparam int TOT_W_DEF       = 8;
   localparam int SYNC_CYCLES_DEF = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SYNC  = 2'd1,
      ST_TRACK = 2'd2
   } chk_state_t;

   typedef enum logic [1:0] {
      EVT_NONE = 2'b00,
      EVT_WRAP = 2'b01,
      EVT_ERR  = 2'b10
   } evt_code_t;

endpackage

// File: rtl/count_sequence_checker_evt_slot.sv
// One-entry event holding register with valid/ready output.
// An event arriving while the slot is full and not being drained is dropped and flagged.
module count_evt_slot
   import count_chk_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             new_vld,
   input  evt_code_t        new_code,
   input  logic [CNT_W-1:0] new_value,
   input  logic             evt_ready,
   output logic             evt_valid,
   output evt_code_t        evt_code,
   output logic [CNT_W-1:0] evt_value,
   output logic             evt_ovf
);

   // Handshake: an event transfers on a posedge where evt_valid && evt_ready;
   // evt_code/evt_value hold steady while evt_valid is high and evt_ready is low,
   // and a transfer plus a new event in one edge reloads the slot with no bubble.
   logic slot_free;

   assign slot_free = !evt_valid || evt_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         evt_valid <= 1'b0;
         evt_code  <= EVT_NONE;
         evt_value <= '0;
         evt_ovf   <= 1'b0;
      end else if (new_vld) begin
         if (slot_free) begin
            evt_valid <= 1'b1;
            evt_code  <= new_code;
            evt_value <= new_value;
         end else begin
            evt_ovf   <= 1'b1;
         end
      end else if (evt_valid && evt_ready) begin
         evt_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/count_sequence_checker.sv
// Observes a free-running counter, checks +1 steps, flags wraps and sequence errors,
// keeps saturating totals and hands one event at a time to a downstream logger.
module count_sequence_checker
   import count_chk_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int TOT_W       = TOT_W_DEF,
   parameter int SYNC_CYCLES = SYNC_CYCLES_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] count,
   input  logic             chk_en,
   output logic             locked,
   output logic             wrap_pulse,
   output logic             err_pulse,
   output logic [TOT_W-1:0] wrap_total,
   output logic [TOT_W-1:0] err_total,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [1:0]       evt_code,
   output logic [CNT_W-1:0] evt_value,
   output logic             evt_ovf
);

   localparam int SC_W = (SYNC_CYCLES < 2) ? 1 : $clog2(SYNC_CYCLES + 1);

   chk_state_t       state, state_nxt;
   logic [SC_W-1:0]  sync_cnt, sync_nxt, sync_inc;
   logic [CNT_W-1:0] prev, exp_cnt;
   logic             prev_vld;
   logic             match, wrap_evt, err_evt;
   evt_code_t        slot_code;

   assign exp_cnt  = prev + CNT_W'(1);
   assign match    = prev_vld && (count == exp_cnt);
   assign sync_inc = sync_cnt + SC_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         sync_cnt <= '0;
         prev     <= '0;
         prev_vld <= 1'b0;
      end else begin
         state    <= state_nxt;
         sync_cnt <= sync_nxt;
         prev_vld <= chk_en;
         if (chk_en) prev <= count;
      end
   end

   always_comb begin
      state_nxt = state;
      sync_nxt  = sync_cnt;
      if (!chk_en) begin
         state_nxt = ST_IDLE;
         sync_nxt  = '0;
      end else begin
         case (state)
            ST_IDLE: begin
               state_nxt = ST_SYNC;
               sync_nxt  = '0;
            end
            ST_SYNC: begin
               if (!match) begin
                  sync_nxt = '0;
               end else if (sync_inc == SC_W'(SYNC_CYCLES)) begin
                  state_nxt = ST_TRACK;
                  sync_nxt  = '0;
               end else begin
                  sync_nxt = sync_inc;
               end
            end
            ST_TRACK: begin
               if (!match) begin
                  state_nxt = ST_SYNC;
                  sync_nxt  = '0;
               end
            end
            default: begin
               state_nxt = ST_IDLE;
               sync_nxt  = '0;
            end
         endcase
      end
   end

   // A wrap is a correct step out of the maximum value, so it never coincides with an error.
   always_comb begin
      locked   = (state == ST_TRACK);
      wrap_evt = chk_en && (state == ST_TRACK) && match && (&prev) && (count == '0);
      err_evt  = chk_en && (state == ST_TRACK) && !match;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wrap_pulse <= 1'b0;
         err_pulse  <= 1'b0;
         wrap_total <= '0;
         err_total  <= '0;
      end else begin
         wrap_pulse <= wrap_evt;
         err_pulse  <= err_evt;
         if (wrap_evt && !(&wrap_total)) wrap_total <= wrap_total + TOT_W'(1);
         if (err_evt && !(&err_total))   err_total  <= err_total + TOT_W'(1);
      end
   end

   count_evt_slot #(
      .CNT_W (CNT_W)
   ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .new_vld   (wrap_evt || err_evt),
      .new_code  (err_evt ? EVT_ERR : EVT_WRAP),
      .new_value (count),
      .evt_ready (evt_ready),
      .evt_valid (evt_valid),
      .evt_code  (slot_code),
      .evt_value (evt_value),
      .evt_ovf   (evt_ovf)
   );

   assign evt_code = slot_code;

endmodule
